rr_wormhole_arbiter: RTL
========================

# rr_wormhole_arbiter

Round-robin, packet-locked (wormhole) arbiter for one router output port in the 2x2 mesh. It takes requests from the input FIFOs routed to this output, grants one requester, and holds the grant until that packet's tail flit has been transferred. Each pop is gated by the downstream ready signal produced by the per-router flow-control logic. One instance sits in front of each output port's crossbar mux and drives the mux select and the input-FIFO read enables.

## Interface
- NREQ, 3, number of competing input ports (L/W/S-style); 2..8
- CNT_W, 16, width of performance counters (only when ARB_PERF_CNT_EN)

- clk  in  1  rising-edge clock
- rst  in  1  reset rst, synchronous, active-high
- req  in  NREQ  req[i]=1: input FIFO i has a non-empty head flit routed to this output
- tail  in  NREQ  tail[i]=1: head flit of FIFO i is a tail flit (head+tail = single-flit packet)
- out_ready  in  1  downstream/flow-control ready for this output
- grant  out  NREQ  one-hot registered grant, crossbar select; all zero when idle
- busy  out  1  arbiter locked to a packet
- pop  out  NREQ  read enable to input FIFO i; asserted for the flit transferred this cycle
- out_valid  out  1  flit presented on output this cycle (= |pop)
- pkt_cnt  out  CNT_W  packets completed (ARB_PERF_CNT_EN only)
- stall_cnt  out  CNT_W  cycles locked with req set but out_ready low (ARB_PERF_CNT_EN only)

## Operation
- States: IDLE, LOCK. Registers: state, grant, rr_ptr (index, log2 NREQ bits).
- IDLE: if |req, pick first set req[i] scanning from rr_ptr upward modulo NREQ; next cycle state=LOCK, grant=onehot(i). No pop in IDLE.
- LOCK: fire = req[g] && out_ready, g = granted index; pop = grant when fire, else 0 (combinational).
- LOCK, fire && tail[g]: next state IDLE, grant=0, rr_ptr=(g+1) mod NREQ (wrap from NREQ-1 to 0).
- LOCK, fire && !tail[g]: stay, grant unchanged.
- LOCK, req[g]=0 (FIFO momentarily empty mid-packet): hold grant, no pop; other requesters ignored.
- Requests from non-granted inputs never affect grant while in LOCK.
- Only the granted index is ever popped; pop is one-hot or zero.
- rst: state=IDLE, grant=0, rr_ptr=0, counters=0; any packet in flight is abandoned, no pop in the reset cycle.

## Timing
- Reset values: grant=0, busy=0, pop=0, out_valid=0, pkt_cnt=0, stall_cnt=0.
- Request to first pop: 1 cycle minimum. req seen in IDLE at cycle t gives grant at t+1, with pop at t+1 if out_ready.
- Throughput in LOCK: 1 flit/cycle while req[g] and out_ready.
- Tail pop at cycle t gives IDLE at t+1, the next grant at t+2: one bubble cycle between packets.
- busy = (state==LOCK), registered. pop/out_valid are combinational from registered grant and inputs.
- out_ready low: pop=0 that cycle. No flit is lost or duplicated.

## Configuration
- ARB_PERF_CNT_EN defined: pkt_cnt increments on every tail pop. stall_cnt increments each LOCK cycle with req[g]=1 and out_ready=0. Both saturate at all-ones and clear on rst.
- ARB_PERF_CNT_EN undefined: counter registers and ports are not generated. Arbitration behaviour is identical.

## Structure
- Shared package router_pkg: arbiter state enum (IDLE, LOCK), NREQ default, CNT_W default, port index constants L/W/S.
- Sub-module rr_pick: purely combinational rotating-priority picker (req, rr_ptr -> onehot, index, any). It is instantiated once and reused by other output ports.

## Test plan
- Single requester: req=001, 3-flit packet with tail on 3rd, out_ready=1. Expect grant=001 at t+1, pop=001 at t+1..t+3, idle at t+4, rr_ptr=1.
- Fairness: req=111 held, single-flit packets. Expect grant order 001,010,100,001 with one idle cycle between each; rr_ptr wraps 2->0.
- Backpressure: locked on input 1, out_ready low 4 cycles mid-packet. Expect pop=0 for those cycles, grant held, stall_cnt=4 (with EN).
- Hold-on-lock: locked on input 0, req[0] drops 2 cycles while req[2]=1. Expect grant stays 001 and no pop to input 2 until input 0's tail pops.
- Reset mid-packet: rst asserted during 2nd flit. Expect grant=0, pop=0 next cycle, rr_ptr=0, counters 0; next arbitration starts from index 0.
- Counter saturation (CNT_W=4, EN): 20 single-flit packets. Expect pkt_cnt stops at 15.

Source files
------------

// File: rtl/router_pkg.sv
// Shared router definitions: arbiter state encoding, default sizes and
// the mesh port indices used when wiring arbiter request vectors.
package router_pkg;

  localparam int unsigned NREQ_DEF  = 3;
  localparam int unsigned CNT_W_DEF = 16;

  // Input-port indices inside an arbiter request vector
  localparam int unsigned PORT_L = 0;
  localparam int unsigned PORT_W = 1;
  localparam int unsigned PORT_S = 2;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: returns the first set request found when
// scanning upward from ptr, wrapping modulo NREQ. Purely combinational.
module rr_pick
  import router_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEF
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         onehot,
  output logic [$clog2(NREQ)-1:0] idx,
  output logic                    any
);

  localparam int unsigned PW = $clog2(NREQ);

  // Scan NREQ positions starting at ptr; the first hit wins
  always_comb begin
    int unsigned j;
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    j      = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      j = (int'(ptr) + k) % NREQ;
      if (!any && req[j]) begin
        any       = 1'b1;
        onehot[j] = 1'b1;
        idx       = PW'(j);
      end
    end
  end

endmodule

// File: rtl/rr_wormhole_arbiter.sv
// Round-robin wormhole arbiter for one router output port. A grant is
// held from the first flit until the tail flit of that packet pops.
// Optional performance counters: define ARB_PERF_CNT_EN.
module rr_wormhole_arbiter
  import router_pkg::*;
#(
  parameter int unsigned NREQ  = NREQ_DEF
`ifdef ARB_PERF_CNT_EN
  ,
  parameter int unsigned CNT_W = CNT_W_DEF
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  tail,
  input  logic             out_ready,
  output logic [NREQ-1:0]  grant,
  output logic             busy,
  output logic [NREQ-1:0]  pop,
  output logic             out_valid
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] pkt_cnt,
  output logic [CNT_W-1:0] stall_cnt
`endif
);

  localparam int unsigned PW = $clog2(NREQ);

  arb_state_e       state_q;
  logic [NREQ-1:0]  grant_q;
  logic [PW-1:0]    gidx_q;
  logic [PW-1:0]    rr_ptr_q;
  logic [PW-1:0]    rr_ptr_d;

  logic [NREQ-1:0]  pick_oh;
  logic [PW-1:0]    pick_idx;
  logic             pick_any;

  logic             locked;
  logic             req_g;
  logic             tail_g;
  logic             fire;

  rr_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .req    (req),
    .ptr    (rr_ptr_q),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // Granted-input view and transfer qualification; reset suppresses pops
  always_comb begin
    locked = (state_q == LOCK);
    req_g  = |(req & grant_q);
    tail_g = |(tail & grant_q);
    fire   = locked && req_g && out_ready && !rst;
  end

  // Pointer moves one past the input whose packet just finished
  always_comb begin
    rr_ptr_d = (gidx_q == PW'(NREQ - 1)) ? '0 : gidx_q + PW'(1);
  end

  // Arbitration FSM: pick in IDLE, hold the grant in LOCK until tail pops
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      gidx_q   <= '0;
      rr_ptr_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            state_q <= LOCK;
            grant_q <= pick_oh;
            gidx_q  <= pick_idx;
          end
        end
        LOCK: begin
          if (fire && tail_g) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= rr_ptr_d;
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

  assign grant     = grant_q;
  assign busy      = locked;
  assign pop       = fire ? grant_q : '0;
  assign out_valid = fire;

`ifdef ARB_PERF_CNT_EN
  logic [CNT_W-1:0] pkt_cnt_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic             stall_ev;

  // A stall is a locked cycle with data waiting but no downstream space
  always_comb begin
    stall_ev = locked && req_g && !out_ready;
  end

  // Saturating packet and stall counters
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (fire && tail_g && (pkt_cnt_q != '1)) begin
        pkt_cnt_q <= pkt_cnt_q + CNT_W'(1);
      end
      if (stall_ev && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
    end
  end

  assign pkt_cnt   = pkt_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule
